// File: rtl/mdu_unit.sv
// mdu_unit: iterative RV32M multiply/divide unit.
//
// Multiplies use 1-bit-per-cycle shift-add on magnitudes and divides use
// 1-bit-per-cycle restoring division on magnitudes. The sign is applied in
// the final CALC cycle. Divide-by-zero and signed overflow finish straight
// from IDLE.
//
// Optional build macro: MDU_FAST_MUL_EN
//   When defined, the four multiplies finish straight from IDLE using a
//   combinational 33x33 signed multiply. Divides are unaffected.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for START with an M-extension opcode (ALU_OP[4:3]=11)
// CALC  | iterating; cnt_q counts 0..31, last step also fixes the sign
// DONE  | RESULT valid, DONE pulse for one cycle, then back to IDLE

module mdu_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [4:0]  ALU_OP,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] p_q, p_d;        // mul: {acc, multiplier}; div: {rem, dividend/quotient}
    logic [31:0] m_q, m_d;        // mul: multiplicand magnitude; div: divisor magnitude
    logic        neg_q, neg_d;    // negate product / quotient
    logic        rneg_q, rneg_d;  // negate remainder (dividend was negative)
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    // Accept-time operand decode
    logic        accept;
    logic        a_signed, b_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf;
    logic [31:0] early_res;

    assign accept   = (state_q == S_IDLE) && START && (ALU_OP[4:3] == 2'b11);
    // MUL is treated as signed; its low word does not depend on signedness.
    assign a_signed = ALU_OP[2] ? ~ALU_OP[1] : (ALU_OP[1:0] != 2'b11);
    assign b_signed = ~ALU_OP[1];
    assign a_neg    = a_signed & DATA1[31];
    assign b_neg    = b_signed & DATA2[31];
    assign a_mag    = a_neg ? (~DATA1 + 32'd1) : DATA1;
    assign b_mag    = b_neg ? (~DATA2 + 32'd1) : DATA2;
    assign div_zero = ALU_OP[2] && (DATA2 == 32'd0);
    assign div_ovf  = ALU_OP[2] && !ALU_OP[1] &&
                      (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);

    // Early-exit results: div-by-zero gives all ones / dividend, overflow gives INT_MIN / 0
    always_comb begin
        early_res = 32'd0;
        if (div_zero) begin
            early_res = ALU_OP[0] ? DATA1 : 32'hFFFF_FFFF;
        end else begin
            early_res = ALU_OP[0] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [63:0] fast_a, fast_b, fast_prod;
    logic        [31:0] fast_res;

    assign fast_a    = {{32{a_neg}}, DATA1};
    assign fast_b    = {{32{b_neg}}, DATA2};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (ALU_OP[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`endif

    // One iteration step for each datapath
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_sh;
    logic        div_qbit;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] step_next;

    assign mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
    assign mul_next  = {mul_sum, p_q[31:1]};
    assign div_sh    = p_q[63:31];
    assign div_qbit  = (div_sh >= {1'b0, m_q});
    assign div_rem   = div_qbit ? (div_sh[31:0] - m_q) : div_sh[31:0];
    assign div_next  = {div_rem, p_q[30:0], div_qbit};
    assign step_next = op_q[2] ? div_next : mul_next;

    // Final-cycle sign correction and result selection
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] calc_res;

    assign prod_fix = neg_q  ? (~step_next + 64'd1) : step_next;
    assign quo_fix  = neg_q  ? (~step_next[31:0] + 32'd1) : step_next[31:0];
    assign rem_fix  = rneg_q ? (~step_next[63:32] + 32'd1) : step_next[63:32];

    always_comb begin
        calc_res = 32'd0;
        if (op_q[2]) begin
            calc_res = op_q[0] ? rem_fix : quo_fix;
        end else begin
            calc_res = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        p_d      = p_q;
        m_d      = m_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = ALU_OP[2:0];
                    cnt_d  = 5'd0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    m_d    = ALU_OP[2] ? b_mag : a_mag;
                    p_d    = {32'd0, (ALU_OP[2] ? a_mag : b_mag)};
                    if (div_zero || div_ovf) begin
                        result_d = early_res;
                        state_d  = S_DONE;
`ifdef MDU_FAST_MUL_EN
                    end else if (!ALU_OP[2]) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                p_d   = step_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = calc_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            p_q      <= 64'd0;
            m_q      <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            p_q      <= p_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = (state_q == S_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed checks of mdu_unit results, latency, busy handling and reset.
module tb_mdu_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [4:0]  ALU_OP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int  errors = 0;
    int  checks = 0;
    time last_acc;

    mdu_unit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .ALU_OP (ALU_OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present one START for a single rising edge; returns at the cycle-1 sample point.
    task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        START  = 1'b1;
        ALU_OP = op;
        DATA1  = a;
        DATA2  = b;
        @(posedge CLK);
        last_acc = $time;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Step until DONE is seen; lat is the cycle index (accept edge = 0), -1 on timeout.
    task automatic wait_done(input int c0, output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        for (int c = c0; c <= 70; c++) begin
            if (DONE === 1'b1) begin
                lat = c;
                res = RESULT;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        RESET  = 1'b0;
        START  = 1'b0;
        ALU_OP = 5'd0;
        DATA1  = 32'd0;
        DATA2  = 32'd0;
        repeat (3) @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
        checks++; if (RESULT !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 00000000", RESULT); end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic run_table(input string tag, input logic [4:0] ops[], input logic [31:0] as[],
                             input logic [31:0] bs[], input logic [31:0] exps[], input int exp_lat);
        int          lat;
        logic [31:0] res;
        for (int i = 0; i < ops.size(); i++) begin
            launch(ops[i], as[i], bs[i]);
            wait_done(1, lat, res);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s_lat[%0d] op=%b: got %0d want %0d", tag, i, ops[i], lat, exp_lat);
            end
            checks++;
            if (res !== exps[i]) begin
                errors++;
                $display("FAIL %s_res[%0d] op=%b a=%h b=%h: got %h want %h", tag, i, ops[i], as[i], bs[i], res, exps[i]);
            end
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL %s_pulse[%0d]: got done=%b busy=%b want 0 0", tag, i, DONE, BUSY);
            end
        end
    endtask

    task automatic test_mul;
        logic [4:0]  ops[]  = '{5'b11000, 5'b11011, 5'b11001, 5'b11010, 5'b11001, 5'b11000, 5'b11010};
        logic [31:0] as[]   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exps[] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
        run_table("mul", ops, as, bs, exps, MUL_LAT);
    endtask

    task automatic test_div;
        logic [4:0]  ops[]  = '{5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b11100, 5'b11101, 5'b11110};
        logic [31:0] as[]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] bs[]   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1};
        logic [31:0] exps[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF};
        run_table("div", ops, as, bs, exps, 33);
    endtask

    task automatic test_div_zero;
        logic [4:0]  ops[]  = '{5'b11100, 5'b11111, 5'b11101, 5'b11110};
        logic [31:0] as[]   = '{32'h1234, 32'h1234, 32'hFFFF_FFF0, 32'd5};
        logic [31:0] bs[]   = '{32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] exps[] = '{32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
        run_table("divzero", ops, as, bs, exps, 1);
    endtask

    task automatic test_overflow;
        int          lat;
        logic [31:0] res;
        launch(5'b11100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, res);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_div_lat: got %0d want 1", lat); end
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div_res: got %h want 80000000", res); end
        // START during the DONE cycle must be ignored
        START  = 1'b1;
        ALU_OP = 5'b11110;
        DATA1  = 32'd100;
        DATA2  = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ovf_busy_start_ignored: got busy=%b want 0", BUSY); end
        @(negedge CLK);
        checks++; if (RESULT !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result_hold: got %h want 80000000", RESULT); end
        launch(5'b11101, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, res);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_rem_lat: got %0d want 1", lat); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL ovf_rem_res: got %h want 00000000", res); end
        @(negedge CLK);
    endtask

    task automatic test_busy_ignore;
        int          lat;
        logic [31:0] res;
        launch(5'b11110, 32'd100, 32'd7);
        repeat (4) @(negedge CLK);
        START  = 1'b1;
        ALU_OP = 5'b11000;
        DATA1  = 32'd3;
        DATA2  = 32'd5;
        @(negedge CLK);
        START = 1'b0;
        wait_done(6, lat, res);
        checks++; if (lat !== 33) begin errors++; $display("FAIL busy_ignore_lat: got %0d want 33", lat); end
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL busy_ignore_res: got %h want 0000000e", res); end
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle: got busy=%b want 0", BUSY); end
    endtask

    task automatic test_illegal_op;
        logic [31:0] prev;
        prev = 32'd14;
        @(negedge CLK);
        START  = 1'b1;
        ALU_OP = 5'b00000;
        DATA1  = 32'd9;
        DATA2  = 32'd0;
        @(negedge CLK);
        ALU_OP = 5'b10100;
        @(negedge CLK);
        START = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL illegal_busy: got %b want 0", BUSY); end
        @(negedge CLK);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL illegal_done: got %b want 0", DONE); end
        checks++; if (RESULT !== prev) begin errors++; $display("FAIL illegal_result: got %h want %h", RESULT, prev); end
    endtask

    task automatic test_back_to_back;
        int          lat;
        logic [31:0] res;
        time         t1;
        launch(5'b11100, 32'hFFFF_FFF9, 32'd2);
        t1 = last_acc;
        wait_done(1, lat, res);
        launch(5'b11111, 32'd100, 32'd7);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", BUSY); end
        checks++; if ((last_acc - t1) !== 64'd340) begin errors++; $display("FAIL b2b_interval: got %0t want 340", last_acc - t1); end
        wait_done(1, lat, res);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_lat: got %0d want 33", lat); end
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL b2b_res: got %h want 00000002", res); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        int          lat;
        logic [31:0] res;
        int          seen;
        launch(5'b11100, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", BUSY); end
        checks++; if (RESULT !== 32'd0) begin errors++; $display("FAIL rst_mid_result: got %h want 00000000", RESULT); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen); end
        RESET  = 1'b1;
        START  = 1'b1;
        ALU_OP = 5'b11110;
        DATA1  = 32'd100;
        DATA2  = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rst_mid_accept: got busy=%b want 1", BUSY); end
        wait_done(1, lat, res);
        checks++; if (lat !== 33) begin errors++; $display("FAIL rst_mid_lat: got %0d want 33", lat); end
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL rst_mid_res: got %h want 0000000e", res); end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_illegal_op();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
